seq_datapath: RTL and testbench

- Parametrised successor to the single-bus register/Y/Z datapath.
- Holds a NREGS x DATA_W register file, the Y and Z latches, and the HI/LO registers, plus an internal T-state sequencer.
- The sequencer executes one register-to-register ALU instruction per accepted request through the shared bus, so the control unit only issues valid/ready requests instead of driving individual Rin/Rout strobes.
- Sits between the future control unit and the memory/MDR path.

---
 rtl/seq_datapath.sv | 184 ++++++++++++++++++
 tb/tb_seq_datapath.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// seq_datapath: register file with Y/Z/HI/LO latches and an internal IDLE->T3->T4->T5 sequencer.
// Optional build macro SEQ_DATAPATH_R0_ZERO_EN hardwires R0 to zero (reads 0, writes discarded).
module seq_datapath #(
    parameter int  DATA_W = 32,
    parameter int  NREGS  = 16,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [AW-1:0]     op_ra,
    input  logic [AW-1:0]     op_rb,
    input  logic [AW-1:0]     op_rc,
    input  logic [DATA_W-1:0] op_imm,
    output logic              done,
    output logic              err,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] bus_out
);
    localparam int SW = $clog2(DATA_W);
`ifdef SEQ_DATAPATH_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_T3 = 2'd1, S_T4 = 2'd2, S_T5 = 2'd3} state_e;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4,  OP_SHRA = 4'd5,  OP_SHL  = 4'd6,  OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8,  OP_NEG  = 4'd9,  OP_NOT  = 4'd10, OP_MUL  = 4'd11;
    localparam logic [3:0] OP_ADDI = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_ILL  = 4'd15;

    state_e              state_q, state_d;
    logic [3:0]          opc_q;
    logic [AW-1:0]       ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   y_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic                done_q, err_q;
    logic [DATA_W-1:0]   bus_s;
    logic [SW-1:0]       amt_s;
    logic                accept_s, rf_we_raw_s, rf_we_s;
    logic [AW-1:0]       rf_wa_s;
    logic [DATA_W-1:0]   rf_wd_s;

    function automatic logic [DATA_W-1:0] r0_mask(input logic [AW-1:0] idx,
                                                  input logic [DATA_W-1:0] val);
        return (R0_ZERO && (idx == '0)) ? '0 : val;
    endfunction

    assign op_ready = (state_q == S_IDLE);
    assign accept_s = op_valid && (state_q == S_IDLE);
    assign amt_s    = bus_s[SW-1:0];
    assign dbg_data = r0_mask(dbg_addr, regs_q[dbg_addr]);
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign bus_out  = bus_s;
    assign done     = done_q;
    assign err      = err_q;
    assign rf_we_s  = rf_we_raw_s && !(R0_ZERO && (rf_wa_s == '0));

    // Sequencer next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = op_valid ? S_T3 : S_IDLE;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shared bus source select
    always_comb begin
        bus_s = '0;
        case (state_q)
            S_T3: bus_s = r0_mask(ra_q, regs_q[ra_q]);
            S_T4: begin
                case (opc_q)
                    OP_ADDI: bus_s = imm_q;
                    OP_MFHI: bus_s = hi_q;
                    OP_MFLO: bus_s = lo_q;
                    default: bus_s = r0_mask(rb_q, regs_q[rb_q]);
                endcase
            end
            S_T5:    bus_s = z_q[DATA_W-1:0];
            default: bus_s = '0;
        endcase
    end

    // ALU: Y op bus; only MUL populates the upper half of Z
    always_comb begin
        z_d = '0;
        case (opc_q)
            OP_ADD:  z_d[DATA_W-1:0] = y_q + bus_s;
            OP_SUB:  z_d[DATA_W-1:0] = y_q - bus_s;
            OP_AND:  z_d[DATA_W-1:0] = y_q & bus_s;
            OP_OR:   z_d[DATA_W-1:0] = y_q | bus_s;
            OP_SHR:  z_d[DATA_W-1:0] = y_q >> amt_s;
            OP_SHRA: z_d[DATA_W-1:0] = $signed(y_q) >>> amt_s;
            OP_SHL:  z_d[DATA_W-1:0] = y_q << amt_s;
            OP_ROR:  z_d[DATA_W-1:0] = DATA_W'({y_q, y_q} >> amt_s);
            OP_ROL:  z_d[DATA_W-1:0] = DATA_W'(({y_q, y_q} << amt_s) >> DATA_W);
            OP_NEG:  z_d[DATA_W-1:0] = -bus_s;
            OP_NOT:  z_d[DATA_W-1:0] = ~bus_s;
            OP_MUL:  z_d = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus_s[DATA_W-1]}}, bus_s};
            OP_ADDI: z_d[DATA_W-1:0] = y_q + bus_s;
            OP_MFHI: z_d[DATA_W-1:0] = bus_s;
            OP_MFLO: z_d[DATA_W-1:0] = bus_s;
            default: z_d = '0;
        endcase
    end

    // Register-file write port: T5 writeback, or external load while idle
    always_comb begin
        rf_we_raw_s = 1'b0;
        rf_wa_s     = ext_addr;
        rf_wd_s     = ext_wdata;
        if (state_q == S_T5) begin
            rf_we_raw_s = (opc_q != OP_MUL) && (opc_q != OP_ILL);
            rf_wa_s     = rc_q;
            rf_wd_s     = bus_s;
        end else if (state_q == S_IDLE) begin
            rf_we_raw_s = ext_we;
        end else begin
            rf_we_raw_s = 1'b0;
        end
    end

    // Register file storage
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we_s) begin
            regs_q[rf_wa_s] <= rf_wd_s;
        end
    end

    // Sequencer state, instruction latch, Y/Z/HI/LO and commit flags
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            opc_q   <= 4'd0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_T4);
            err_q   <= (state_q == S_T4) && (opc_q == OP_ILL);
            if (accept_s) begin
                opc_q <= op_code;
                ra_q  <= op_ra;
                rb_q  <= op_rb;
                rc_q  <= op_rc;
                imm_q <= op_imm;
            end
            if (state_q == S_T3) y_q <= bus_s;
            if (state_q == S_T4) z_q <= z_d;
            if ((state_q == S_T5) && (opc_q == OP_MUL)) begin
                hi_q <= z_q[2*DATA_W-1:DATA_W];
                lo_q <= z_q[DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: directed and random instructions against an arithmetic model.
// Expectations follow SEQ_DATAPATH_R0_ZERO_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_seq_datapath;
    localparam int NR = 16;
`ifdef SEQ_DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        Clock = 1'b0, Clear = 1'b0, op_valid = 1'b0, op_ready, done, err;
    logic [3:0]  op_code = 4'd0, op_ra = 4'd0, op_rb = 4'd0, op_rc = 4'd0;
    logic [31:0] op_imm = 32'd0, ext_wdata = 32'd0;
    logic        ext_we = 1'b0;
    logic [3:0]  ext_addr = 4'd0, dbg_addr, sweep_addr = 4'd0, mon_addr = 4'd0;
    logic        sweep_on = 1'b0;
    logic [31:0] dbg_data, hi_out, lo_out, bus_out;

    assign dbg_addr = sweep_on ? sweep_addr : mon_addr;

    seq_datapath dut (
        .Clock(Clock), .Clear(Clear), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_ra(op_ra), .op_rb(op_rb), .op_rc(op_rc), .op_imm(op_imm),
        .done(done), .err(err), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .hi_out(hi_out), .lo_out(lo_out),
        .bus_out(bus_out)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [3:0]  rc;
        logic [31:0] rcv, hi, lo;
        int          acc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mdl [NR];
    logic [31:0] mhi, mlo;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: what the instruction computes, from the opcode table
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, b, imm, h, l);
        logic [31:0] r;
        int n;
        longint p;
        r = 32'd0;
        n = int'(b % 32);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a >> n;
            4'd5:  begin r = a; for (int k = 0; k < n; k++) r = {r[31], r[31:1]}; end
            4'd6:  r = a << n;
            4'd7:  begin r = a; for (int k = 0; k < n; k++) r = {r[0], r[31:1]}; end
            4'd8:  begin r = a; for (int k = 0; k < n; k++) r = {r[30:0], r[31]}; end
            4'd9:  r = 32'd0 - b;
            4'd10: r = ~b;
            4'd11: begin p = longint'(signed'(a)) * longint'(signed'(b)); return 64'(p); end
            4'd12: r = a + imm;
            4'd13: r = h;
            4'd14: r = l;
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (!(R0Z && a == 4'd0)) mdl[a] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = 32'd0;
        mhi = 32'd0;
        mlo = 32'd0;
    endtask

    // Called just after an accepting edge, with the inputs that edge saw
    task automatic do_accept();
        exp_t e;
        logic [63:0] res;
        if (ext_we) model_write(ext_addr, ext_wdata);
        res = ref_op(op_code, mdl[op_ra], mdl[op_rb], op_imm, mhi, mlo);
        if (op_code == 4'd11) begin
            mhi = res[63:32];
            mlo = res[31:0];
        end else if (op_code != 4'd15) begin
            model_write(op_rc, res[31:0]);
        end
        e.err = (op_code == 4'd15);
        e.rc  = op_rc;
        e.rcv = mdl[op_rc];
        e.hi  = mhi;
        e.lo  = mlo;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge Clock);
        while (!op_ready && g < 50) begin @(negedge Clock); g++; end
        if (!op_ready) chk("ready_timeout", {31'd0, op_ready}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, ra, rb, rc, input logic [31:0] imm,
                         input bit ewe = 1'b0, input logic [3:0] ea = 4'd0, input logic [31:0] ed = 32'd0);
        wait_ready();
        op_code = op; op_ra = ra; op_rb = rb; op_rc = rc; op_imm = imm;
        ext_we = ewe; ext_addr = ea; ext_wdata = ed;
        op_valid = 1'b1;
        @(posedge Clock); #1;
        do_accept();
        op_valid = 1'b0;
        ext_we = 1'b0;
    endtask

    task automatic ext_load(input logic [3:0] a, input logic [31:0] d);
        wait_ready();
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        @(posedge Clock); #1;
        model_write(a, d);
        ext_we = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin @(negedge Clock); g++; end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic rd_reg(input logic [3:0] i, output logic [31:0] v);
        sweep_on = 1'b1; sweep_addr = i; #1;
        v = dbg_data;
        sweep_on = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] i, input logic [31:0] expv);
        logic [31:0] v;
        rd_reg(i, v);
        chk(name, v, expv);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NR; i++) chk_reg($sformatf("%s_R%0d", tag, i), 4'(i), mdl[i]);
        chk({tag, "_hi"}, hi_out, mhi);
        chk({tag, "_lo"}, lo_out, mlo);
    endtask

    task automatic rand_fields();
        op_code = 4'($urandom_range(0, 15));
        op_ra   = 4'($urandom_range(0, 15));
        op_rb   = 4'($urandom_range(0, 15));
        op_rc   = 4'($urandom_range(0, 15));
        op_imm  = $urandom;
    endtask

    task automatic b2b(input int n);
        int accs[$];
        bit rdy;
        int g = 0;
        @(negedge Clock);
        rand_fields();
        op_valid = 1'b1;
        while (accs.size() < n && g < 100) begin
            rdy = op_ready;
            @(posedge Clock); #1;
            if (rdy) begin do_accept(); accs.push_back(cyc); rand_fields(); end
            @(negedge Clock);
            g++;
        end
        op_valid = 1'b0;
        if (accs.size() < n) chk("b2b_timeout", 32'(accs.size()), 32'(n));
        for (int i = 1; i < accs.size(); i++) chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd4);
    endtask

    // Monitor: pops the scoreboard on every done and checks the committed state
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Clear && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("latency", 32'(cyc), 32'(e.acc + 2));
                    @(negedge Clock);
                    chk("done_pulse", {31'd0, done}, 32'd0);
                    mon_addr = e.rc; #1;
                    chk("rc_value", dbg_data, e.rcv);
                    chk("hi", hi_out, e.hi);
                    chk("lo", lo_out, e.lo);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        model_reset();
        #22 Clear = 1'b1;
        @(negedge Clock);
        chk("reset_ready", {31'd0, op_ready}, 32'd1);
        sweep("reset");

        ext_load(4'd2, 32'h5);
        ext_load(4'd4, 32'h7);
        issue(4'd0, 4'd2, 4'd4, 4'd5, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            chk("busy_ready", {31'd0, op_ready}, 32'd0);
        end
        @(negedge Clock);
        chk("ready_back", {31'd0, op_ready}, 32'd1);
        drain();
        chk_reg("add_R5", 4'd5, 32'h0000000C);

        issue(4'd0, 4'd2, 4'd4, 4'd5, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Clear = 1'b0;
        sb.delete();
        model_reset();
        @(negedge Clock);
        Clear = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge Clock); if (done) seen = 1'b1; end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_ready", {31'd0, op_ready}, 32'd1);
        sweep("abort");

        ext_load(4'd1, 32'hFFFFFFFF);
        ext_load(4'd2, 32'h1);
        issue(4'd1, 4'd1, 4'd2, 4'd3, 32'd0);
        ext_load(4'd9, 32'd33);
        issue(4'd8, 4'd1, 4'd9, 4'd10, 32'd0);
        drain();
        chk_reg("sub_R3", 4'd3, 32'hFFFFFFFE);
        chk_reg("rol_R10", 4'd10, 32'hFFFFFFFF);

        ext_load(4'd6, 32'hFFFFFFFE);
        ext_load(4'd7, 32'h3);
        issue(4'd11, 4'd6, 4'd7, 4'd5, 32'd0);
        issue(4'd13, 4'd0, 4'd0, 4'd8, 32'd0);
        issue(4'd14, 4'd0, 4'd0, 4'd12, 32'd0);
        drain();
        chk("mul_hi", hi_out, 32'hFFFFFFFF);
        chk("mul_lo", lo_out, 32'hFFFFFFFA);
        chk_reg("mul_R5", 4'd5, 32'h0);
        chk_reg("mfhi_R8", 4'd8, 32'hFFFFFFFF);
        chk_reg("mflo_R12", 4'd12, 32'hFFFFFFFA);

        issue(4'd15, 4'd1, 4'd2, 4'd3, 32'd0);
        drain();
        chk_reg("ill_R3", 4'd3, 32'hFFFFFFFE);

        issue(4'd0, 4'd14, 4'd14, 4'd15, 32'd0, 1'b1, 4'd14, 32'h100);
        issue(4'd2, 4'd1, 4'd1, 4'd1, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        ext_we = 1'b1; ext_addr = 4'd13; ext_wdata = 32'hDEADBEEF;
        @(posedge Clock); #1;
        ext_we = 1'b0;
        drain();
        chk_reg("same_edge_R15", 4'd15, 32'h200);
        chk_reg("ext_t4_R13", 4'd13, mdl[13]);

        b2b(6);
        drain();

        ext_load(4'd0, 32'h1234);
        chk_reg("r0_ext", 4'd0, R0Z ? 32'h0 : 32'h1234);
        issue(4'd12, 4'd0, 4'd0, 4'd0, 32'd5);
        drain();
        chk_reg("r0_addi", 4'd0, R0Z ? 32'h0 : 32'h1239);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                ext_load(4'($urandom_range(0, 15)), $urandom);
            end else begin
                rand_fields();
                issue(op_code, op_ra, op_rb, op_rc, op_imm);
            end
            repeat ($urandom_range(0, 2)) @(negedge Clock);
        end
        drain();
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
